pp_accum_pipe: RTL and testbench

- Consumer side of the partial-product registers in the 8-bit radix-4 Booth multiplier.
- Takes four 16-bit partial products in one transaction. Each is already sign-extended and shifted by 0/2/4/6.
- Sums them through a 2-stage valid/ready adder-tree pipeline and presents the 16-bit signed product.
- Sits between the partial-product register bank and the product output register.

---
 rtl/booth_pkg.sv | 16 +
 rtl/pp_pipe_stage.sv | 54 +++++
 rtl/pp_accum_pipe.sv | 91 +++++++++
 tb/tb_pp_accum_pipe.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier datapath.
// Holds the partial-product geometry and the completion-counter width.
package booth_pkg;

  localparam int PP_W   = 16;
  localparam int NUM_PP = 4;
  localparam int CNT_W  = 8;

  typedef logic [PP_W-1:0] pp_t;

  // Two's complement add that drops the carry-out, matching the product width.
  function automatic pp_t pp_add(input pp_t a, input pp_t b);
    return a + b;
  endfunction

endpackage

// File: rtl/pp_pipe_stage.sv
// One valid/ready pipeline register with synchronous flush.
// The stage advances when it is empty or downstream is taking its contents;
// a stalled stage holds both data and valid so nothing is lost or repeated.
module pp_pipe_stage
  import booth_pkg::*;
#(
  parameter int DW = PP_W
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          flush_i,
  input  logic          up_valid_i,
  input  logic [DW-1:0] up_data_i,
  output logic          up_ready_o,
  input  logic          dn_ready_i,
  output logic          dn_valid_o,
  output logic [DW-1:0] dn_data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          adv;

  assign adv        = !valid_q || dn_ready_i;
  assign up_ready_o = adv;
  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;

  // Next state: flush empties the stage, otherwise advance takes whatever is offered.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        data_d = up_data_i;
      end
    end
  end

  // Stage register with asynchronous clear.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pp_accum_pipe.sv
// Partial-product accumulator for the 8-bit radix-4 Booth multiplier.
// Sums four pre-shifted, sign-extended partial products through a two-stage
// valid/ready adder tree: stage 1 holds pp0+pp1 and pp2+pp3, stage 2 holds
// the final product. All adds wrap modulo 2^W.
// Optional build macro PP_ACCUM_CNT_EN adds the 8-bit done_cnt output that
// counts completed output transfers (cleared by clr, untouched by flush).
module pp_accum_pipe
  import booth_pkg::*;
#(
  parameter int W = PP_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [W-1:0]     pp0,
  input  logic [W-1:0]     pp1,
  input  logic [W-1:0]     pp2,
  input  logic [W-1:0]     pp3,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [W-1:0]     product,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PP_ACCUM_CNT_EN
  ,
  output logic [CNT_W-1:0] done_cnt
`endif
);

  logic [W-1:0]   s01_d, s23_d;
  logic [W-1:0]   s01_q, s23_q;
  logic [2*W-1:0] s1_data;
  logic [W-1:0]   sum_d;
  logic           s1_valid;
  logic           s2_adv;

  assign s01_d = pp0 + pp1;
  assign s23_d = pp2 + pp3;

  pp_pipe_stage #(.DW(2*W)) u_stage1 (
    .clk_i      (clk),
    .clr_i      (clr),
    .flush_i    (flush),
    .up_valid_i (in_valid),
    .up_data_i  ({s01_d, s23_d}),
    .up_ready_o (in_ready),
    .dn_ready_i (s2_adv),
    .dn_valid_o (s1_valid),
    .dn_data_o  (s1_data)
  );

  assign s01_q = s1_data[2*W-1:W];
  assign s23_q = s1_data[W-1:0];
  assign sum_d = s01_q + s23_q;

  pp_pipe_stage #(.DW(W)) u_stage2 (
    .clk_i      (clk),
    .clr_i      (clr),
    .flush_i    (flush),
    .up_valid_i (s1_valid),
    .up_data_i  (sum_d),
    .up_ready_o (s2_adv),
    .dn_ready_i (out_ready),
    .dn_valid_o (out_valid),
    .dn_data_o  (product)
  );

`ifdef PP_ACCUM_CNT_EN
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  assign done_cnt = done_cnt_q;

  // Count every product the downstream register actually takes.
  always_comb begin
    done_cnt_d = done_cnt_q;
    if (out_valid && out_ready) begin
      done_cnt_d = done_cnt_q + CNT_W'(1);
    end
  end

  // Completion counter survives flush; only clr resets it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      done_cnt_q <= '0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pp_accum_pipe.sv
// Self-checking bench for pp_accum_pipe. Expected sums are pushed when a
// transaction is accepted and compared when the product is taken downstream.
module tb_pp_accum_pipe;

  logic        clk;
  logic        clr;
  logic [15:0] pp0, pp1, pp2, pp3;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] product;
  logic        out_valid;
  logic        out_ready;
`ifdef PP_ACCUM_CNT_EN
  logic [7:0]  done_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cycleNo = 0;

  logic [15:0] expQ[$];
  logic [15:0] obsQ[$];
  int          expCycQ[$];
  int          obsCycQ[$];

  pp_accum_pipe dut (
    .clk       (clk),
    .clr       (clr),
    .pp0       (pp0),
    .pp1       (pp1),
    .pp2       (pp2),
    .pp3       (pp3),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PP_ACCUM_CNT_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: four-way add truncated to 16 bits.
  function automatic logic [15:0] modelSum(input logic [15:0] a, b, c, d);
    logic [15:0] s;
    s = a + b;
    s = s + c;
    s = s + d;
    return s;
  endfunction

  task automatic setPp(input logic [15:0] a, b, c, d);
    pp0 = a; pp1 = b; pp2 = c; pp3 = d;
  endtask

  // Called at a falling edge with inputs already driven; records handshakes
  // for this cycle, then advances to the next falling edge.
  task automatic tick();
    int inFlight;
    #1;
    if (out_valid && out_ready) begin
      obsQ.push_back(product);
      obsCycQ.push_back(cycleNo);
    end
    if (flush) begin
      inFlight = expQ.size() - obsQ.size();
      repeat (inFlight) begin
        void'(expQ.pop_back());
        void'(expCycQ.pop_back());
      end
    end else if (in_valid && in_ready) begin
      expQ.push_back(modelSum(pp0, pp1, pp2, pp3));
      expCycQ.push_back(cycleNo);
    end
    @(posedge clk);
    @(negedge clk);
    cycleNo++;
  endtask

  task automatic drain(input int budget, output bit ok);
    in_valid = 1'b0;
    flush    = 1'b0;
    ok       = 1'b1;
    while (obsQ.size() < expQ.size()) begin
      if (budget == 0) begin
        ok = 1'b0;
        break;
      end
      tick();
      budget--;
    end
  endtask

  task automatic clearModel();
    expQ.delete();
    obsQ.delete();
    expCycQ.delete();
    obsCycQ.delete();
  endtask

  task automatic test_reset();
    clr = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    setPp(16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
    vectors++;
    if (product !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_product: got %h, expected 0000", product); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready); end
`ifdef PP_ACCUM_CNT_EN
    vectors++;
    if (done_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_done_cnt: got %0d, expected 0", done_cnt); end
`endif
    clr = 1'b0;
    @(negedge clk);
    clearModel();
  endtask

  task automatic test_basic();
    bit ok;
    out_ready = 1'b1;
    setPp(16'h0001, 16'h0002, 16'h0004, 16'h0008);
    in_valid = 1'b1;
    tick();
    drain(10, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL basic_timeout: got %0d outputs, expected %0d", obsQ.size(), expQ.size()); end
    vectors++;
    if (expQ.size() != 1 || expQ[0] !== 16'h000F) begin miscompares++; $display("[TB] FAIL basic_model: got %0d entries, expected one 000F", expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      logic [15:0] e, o;
      int ec, oc;
      e = expQ.pop_front(); o = obsQ.pop_front();
      ec = expCycQ.pop_front(); oc = obsCycQ.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL basic_product: got %h, expected %h", o, e); end
      vectors++;
      if (oc - ec != 2) begin miscompares++; $display("[TB] FAIL basic_latency: got %0d, expected 2", oc - ec); end
    end
    clearModel();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [15:0] vecs [5][4];
    vecs[0] = '{16'h0007, 16'hFFE4, 16'h0000, 16'h0000};
    vecs[1] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{16'h1234, 16'h0F00, 16'hA000, 16'h00C0};
    vecs[4] = '{16'hFFFD, 16'h0018, 16'hFF40, 16'h0000};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      setPp(vecs[i][0], vecs[i][1], vecs[i][2], vecs[i][3]);
      in_valid = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_in_ready[%0d]: got %b, expected 1", i, in_ready); end
      tick();
    end
    drain(10, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL b2b_timeout: got %0d outputs, expected %0d", obsQ.size(), expQ.size()); end
    vectors++;
    if (expQ[0] !== 16'hFFEB || expQ[1] !== 16'h0000 || expQ[2] !== 16'hFFFC) begin
      miscompares++; $display("[TB] FAIL b2b_model: got %h %h %h, expected FFEB 0000 FFFC", expQ[0], expQ[1], expQ[2]);
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      logic [15:0] e, o;
      int ec, oc;
      e = expQ.pop_front(); o = obsQ.pop_front();
      ec = expCycQ.pop_front(); oc = obsCycQ.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL b2b_product: got %h, expected %h", o, e); end
      vectors++;
      if (oc - ec != 2) begin miscompares++; $display("[TB] FAIL b2b_latency: got %0d, expected 2", oc - ec); end
    end
    clearModel();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [15:0] fill [3];
    logic [15:0] want [3];
    fill = '{16'h0004, 16'h0008, 16'h000C};
    want = '{16'h0010, 16'h0020, 16'h0030};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setPp(fill[i], fill[i], fill[i], fill[i]);
      in_valid = 1'b1;
      #1;
      vectors++;
      if (in_ready !== (i < 2)) begin miscompares++; $display("[TB] FAIL bp_in_ready[%0d]: got %b, expected %b", i, in_ready, i < 2); end
      tick();
    end
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_hold_in_ready: got %b, expected 0", in_ready); end
    tick();
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_release_in_ready: got %b, expected 1", in_ready); end
    tick();
    drain(10, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL bp_timeout: got %0d outputs, expected %0d", obsQ.size(), expQ.size()); end
    vectors++;
    if (obsQ.size() != 3) begin miscompares++; $display("[TB] FAIL bp_count: got %0d outputs, expected 3", obsQ.size()); end
    for (int i = 0; i < 3 && obsQ.size() > 0; i++) begin
      logic [15:0] o;
      o = obsQ.pop_front();
      vectors++;
      if (o !== want[i]) begin miscompares++; $display("[TB] FAIL bp_order[%0d]: got %h, expected %h", i, o, want[i]); end
      if (expQ.size() > 0) begin
        logic [15:0] e;
        e = expQ.pop_front();
        vectors++;
        if (o !== e) begin miscompares++; $display("[TB] FAIL bp_scoreboard[%0d]: got %h, expected %h", i, o, e); end
      end
    end
    clearModel();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      setPp(16'h0100, 16'h0000, 16'h0000, 16'h00AA + 16'(i));
      in_valid = 1'b1;
      tick();
    end
    setPp(16'h0300, 16'h0000, 16'h0000, 16'h0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_out_valid: got %b, expected 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_in_ready: got %b, expected 1", in_ready); end
    // Flush on an empty pipe while an input is offered and in_ready is high.
    setPp(16'h0055, 16'h0000, 16'h0000, 16'h0000);
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_empty_in_ready: got %b, expected 1", in_ready); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    vectors++;
    if (obsQ.size() != 0) begin miscompares++; $display("[TB] FAIL flush_leak: got %0d outputs (first %h), expected 0", obsQ.size(), obsQ[0]); end
    clearModel();
  endtask

  task automatic test_async_clr();
    out_ready = 1'b1;
    setPp(16'h1111, 16'h2222, 16'h0000, 16'h0000);
    in_valid = 1'b1;
    tick();
    setPp(16'h0101, 16'h0000, 16'h0000, 16'h0000);
    tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL clr_pre_out_valid: got %b, expected 1", out_valid); end
    #1;
    clr = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_out_valid: got %b, expected 0", out_valid); end
    vectors++;
    if (product !== 16'h0) begin miscompares++; $display("[TB] FAIL clr_product: got %h, expected 0000", product); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL clr_in_ready: got %b, expected 1", in_ready); end
    @(negedge clk);
    clr = 1'b0;
    clearModel();
    repeat (3) tick();
    vectors++;
    if (obsQ.size() != 0) begin miscompares++; $display("[TB] FAIL clr_leak: got %0d outputs, expected 0", obsQ.size()); end
    clearModel();
  endtask

`ifdef PP_ACCUM_CNT_EN
  task automatic test_counter();
    bit ok;
    int seen;
    clr = 1'b1;
    #1;
    clr = 1'b0;
    @(negedge clk);
    clearModel();
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      setPp(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      in_valid = 1'b1;
      tick();
    end
    drain(20, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL cnt_timeout: got %0d outputs, expected %0d", obsQ.size(), expQ.size()); end
    seen = 0;
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      logic [15:0] e, o;
      e = expQ.pop_front(); o = obsQ.pop_front();
      seen++;
      vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL cnt_product[%0d]: got %h, expected %h", seen, o, e); end
    end
    #1;
    vectors++;
    if (done_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL cnt_wrap: got %0d, expected 1", done_cnt); end
    clearModel();
    out_ready = 1'b0;
    setPp(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    in_valid = 1'b1;
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    #1;
    vectors++;
    if (done_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL cnt_flush: got %0d, expected 1", done_cnt); end
    clr = 1'b1;
    #1;
    vectors++;
    if (done_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL cnt_clr: got %0d, expected 0", done_cnt); end
    @(negedge clk);
    clr = 1'b0;
    clearModel();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_clr();
`ifdef PP_ACCUM_CNT_EN
    test_counter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
